// File: rtl/imm_pack.sv
// RV32I immediate packer: places an immediate into instr[31:7] over a base word,
// range-checks it, and buffers {data, err} in a small registered output FIFO.
module imm_pack #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [24:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_data,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [24:0]   pk_data;
  logic          pk_err;
  logic          push;
  logic          pop;

  logic [25:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    errc_q, errc_d;

  always_comb begin
    pk_data = base;
    pk_err  = 1'b0;
    case (imm_src)
      3'b000: begin
        pk_data[24:13] = imm[11:0];
        pk_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b001: begin
        pk_data[24:18] = imm[11:5];
        pk_data[4:0]   = imm[4:0];
        pk_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      3'b010: begin
        pk_data[24]    = imm[12];
        pk_data[23:18] = imm[10:5];
        pk_data[4:1]   = imm[4:1];
        pk_data[0]     = imm[11];
        pk_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
      end
      3'b011: begin
        pk_data[24]    = imm[20];
        pk_data[23:14] = imm[10:1];
        pk_data[13]    = imm[11];
        pk_data[12:5]  = imm[19:12];
        pk_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      3'b100: begin
        pk_data[24:5] = imm[31:12];
        pk_err = |imm[11:0];
      end
      default: pk_err = 1'b1;
    endcase
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign in_ready  = rst || (cnt_q != CW'(DEPTH)) || out_ready;
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = mem_q[rd_q][24:0];
  assign out_err   = mem_q[rd_q][25];
  assign err_count = errc_q;

  always_comb begin
    rd_d   = pop  ? rd_q + PW'(1) : rd_q;
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    errc_d = errc_q;
    if (push && pk_err && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      errc_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      errc_q <= errc_d;
      if (push) mem_q[wr_q] <= {pk_err, pk_data};
    end
  end

endmodule

// File: doc/imm_pack.md
# imm_pack

Immediate packer for the RV32I pipeline. It inverts the immediate sign-extender: it takes a 32-bit immediate value plus a format selector and places the immediate bits into the 25-bit instruction field `instr[31:7]`. Non-immediate bits come from a caller-supplied base word. It is used by the instruction-generation/self-test path that feeds the instruction memory. It range-checks each immediate, flags values that cannot be encoded, and buffers results in a 2-entry output FIFO behind valid/ready handshakes.

## Interface
- `DEPTH`, 2: output FIFO depth. Fixed at 2; other values are not supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high (one clock; polarity and synchronicity fixed).
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted this cycle when `in_valid && in_ready`.
- `imm_src`  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 illegal.
- `imm`  in  32  immediate value (two's complement; U holds the final upper value).
- `base`  in  25  `instr[31:7]` with rs1/rs2/rd/funct fields; immediate positions are ignored.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head when `out_valid && out_ready`.
- `out_data`  out  25  packed `instr[31:7]` (bit 0 = `instr[7]`).
- `out_err`  out  1  head entry failed its range check or had an illegal `imm_src`.
- `err_count`  out  8  saturating count of accepted erroneous requests.

## Operation
- Packing, with `d = out_data`. All positions not listed are taken from `base`.
  - I: `d[24:13]=imm[11:0]`.
  - S: `d[24:18]=imm[11:5]`, `d[4:0]=imm[4:0]`.
  - B: `d[24]=imm[12]`, `d[23:18]=imm[10:5]`, `d[4:1]=imm[4:1]`, `d[0]=imm[11]`.
  - J: `d[24]=imm[20]`, `d[23:14]=imm[10:1]`, `d[13]=imm[11]`, `d[12:5]=imm[19:12]`.
  - U: `d[24:5]=imm[31:12]`.
  - Illegal `imm_src`: `d=base`, error set.
- Range checks (error when violated):
  - I/S: `imm[31:11]` all equal.
  - B: `imm[0]==0` and `imm[31:12]` all equal.
  - J: `imm[0]==0` and `imm[31:20]` all equal.
  - U: `imm[11:0]==0`.
- An erroneous entry is still packed with truncated bits, enqueued, and delivered with `out_err=1`. It never stalls the pipe.
- FIFO: 2 entries of {data, err}. Track occupancy `count` ∈ {0,1,2} with a read pointer and a write pointer, both wrapping mod 2.
- `push = in_valid && in_ready`; `pop = out_valid && out_ready`.
- `in_ready = (count != 2) || out_ready`. When full, simultaneous pop and push is allowed and `count` stays 2.
- `out_valid = (count != 0)`. `out_data`/`out_err` are registered FIFO head contents; there is no combinational path from `imm`/`base` to the outputs.
- `err_count` increments on each push with error, saturating at 255. It clears only on `rst`.
- Holding: `out_data`/`out_err` stay stable while `out_valid && !out_ready`.

## Timing
- Reset (synchronous, `rst` high at a rising edge):
  - `count=0` and pointers 0.
  - `out_valid=0`, `out_data=0`, `out_err=0`, `err_count=0`.
  - `in_ready` reads 1 during and after reset.
- Reset mid-operation: all buffered entries are discarded. A push presented in the reset cycle is dropped.
- Latency: a request pushed at edge N is visible on the outputs after edge N (`out_valid` high in cycle N+1) if the FIFO was empty. Otherwise it waits behind the entries ahead of it.
- Throughput: 1 request per cycle with `out_ready` held high.
- Empty with push and no pop: `count` goes 0→1. Pop on the last entry with no push: `count` goes 1→0 and `out_valid` falls next cycle.
- Empty with `out_ready` high and a push: no bypass. The entry appears on the next cycle.
- Full with `out_ready=0`: `in_ready=0`. `in_valid` held high is not accepted, and the FIFO contents are unchanged.

## Test plan
- I-type: `imm=0xFFFFF800` (-2048), `base=0` → `out_data=0x1000000` (`d[24:13]=0x800`), `out_err=0`. Then `imm=0x800` → `out_err=1`, `err_count=1`.
- B-type: `imm=0x00000FFE`, `base=0x0000F80` → `d[24]=0`, `d[23:18]=0x3F`, `d[4:1]=0xF`, `d[0]=1`, other bits from `base`. Then `imm=0x3` → error (odd offset).
- J/U: J `imm=0x000FFFFE` → `d[24]=0`, `d[23:14]=0x3FF`, `d[13]=1`, `d[12:5]=0xFF`, no error. U `imm=0x12345000` → `d[24:5]=0x12345`. U `imm=0x12345001` → `out_err=1`.
- Backpressure: `out_ready=0`, push 3 requests back-to-back:
  - first two accepted, `in_ready=0` on the third;
  - raise `out_ready` → third accepted in the same cycle as the first pop;
  - order preserved and outputs stable while stalled.
- Saturation/illegal: 260 pushes with `imm_src=111` → every output has `out_err=1` and `out_data=base`, `err_count` saturates at 255.
- Reset with 2 entries buffered → next cycle `out_valid=0`, `err_count=0`, `in_ready=1`. A push in the reset cycle never appears at the output.
